riscv_lsu: RTL

Parametrised load/store unit between the core's Datapath and data memory. It replaces the single-cycle rd/wr/addr/wr_data/rd_data strobes with a request/acknowledge bus that tolerates wait states. It stalls the core while an access is in flight and performs byte-lane steering, byte enables, sign/zero extension and alignment checks. Data width and address width are generic.

---
 rtl/riscv_lsu_pkg.sv | 41 ++++
 rtl/riscv_lsu_align.sv | 63 ++++++
 rtl/riscv_lsu.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types and helpers for the riscv_lsu load/store unit: FSM state
// encoding, RISC-V load/store funct3 codes, access size and alignment helpers.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Access size in bytes (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

    // Only the low three address bits matter for sizes up to 8 bytes.
    function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [3:0] size);
        logic ok;
        case (size)
            4'd1:    ok = 1'b1;
            4'd2:    ok = (addr_lo[0] == 1'b0);
            4'd4:    ok = (addr_lo[1:0] == 2'b00);
            4'd8:    ok = (addr_lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational byte-lane logic for riscv_lsu: store data replication, byte
// enables, and load data shift with sign/zero extension.
module lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                      funct3_i,
    input  logic [$clog2(DATA_W/8)-1:0]     off_i,
    input  logic [DATA_W-1:0]               wdata_i,
    input  logic [DATA_W-1:0]               rdata_i,
    output logic [DATA_W-1:0]               wdata_o,
    output logic [DATA_W/8-1:0]             be_o,
    output logic [DATA_W-1:0]               rdata_o
);
    localparam int NB = DATA_W / 8;

    logic [3:0]        size_s;
    logic [NB:0]       mask_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] keep_s;
    logic              sign_s;

    assign size_s    = size_bytes(funct3_i);
    // One spare bit so a full-width mask does not wrap before the subtract.
    assign mask_s    = ({{NB{1'b0}}, 1'b1} << size_s) - {{NB{1'b0}}, 1'b1};
    assign be_o      = mask_s[NB-1:0] << off_i;
    assign shifted_s = rdata_i >> {off_i, 3'b000};

    // Replicate the low size bytes of the store data across every lane.
    always_comb begin
        wdata_o = '0;
        for (int b = 0; b < NB; b++) begin
            case (funct3_i[1:0])
                2'd0:    wdata_o[8*b +: 8] = wdata_i[7:0];
                2'd1:    wdata_o[8*b +: 8] = wdata_i[8*(b%2) +: 8];
                2'd2:    wdata_o[8*b +: 8] = wdata_i[8*(b%4) +: 8];
                default: wdata_o[8*b +: 8] = wdata_i[8*(b%8) +: 8];
            endcase
        end
    end

    // Keep mask for the loaded bytes and the sign bit of the loaded value.
    always_comb begin
        keep_s = '0;
        for (int b = 0; b < NB; b++) begin
            if (4'(b) < size_s) begin
                keep_s[8*b +: 8] = 8'hFF;
            end else begin
                keep_s[8*b +: 8] = 8'h00;
            end
        end
        case (funct3_i[1:0])
            2'd0:    sign_s = ~funct3_i[2] & shifted_s[7];
            2'd1:    sign_s = ~funct3_i[2] & shifted_s[15];
            2'd2:    sign_s = ~funct3_i[2] & shifted_s[31];
            default: sign_s = ~funct3_i[2] & shifted_s[DATA_W-1];
        endcase
    end

    assign rdata_o = (shifted_s & keep_s) | (sign_s ? ~keep_s : {DATA_W{1'b0}});

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: request/acknowledge memory bus with wait states, core stall,
// lane steering and alignment checks. Define LSU_TIMEOUT_EN for the ACCESS timeout.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TMO_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                stall,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                misalign,
    output logic                bus_err,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e          state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                legal_s, idle_s, access_s, resp_s, tmo_s;
    logic [DATA_W-1:0]   wrep_s, rext_s;
    logic [NB-1:0]       be_s;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    assign tmo_s = (cnt_q == CNT_W'(TMO_CYC - 1));
`else
    assign tmo_s = 1'b0;
`endif

    assign idle_s   = (state_q == ST_IDLE);
    assign access_s = (state_q == ST_ACCESS);
    assign resp_s   = (state_q == ST_RESP);
    assign legal_s  = (size_bytes(req_funct3) <= 4'(NB)) &&
                      is_aligned(req_addr[2:0], size_bytes(req_funct3));

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3_i (f3_q),
        .off_i    (addr_q[OFF_W-1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_rdata),
        .wdata_o  (wrep_s),
        .be_o     (be_s),
        .rdata_o  (rext_s)
    );

    // Next-state logic: accept, wait for ack (or timeout), retire.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && legal_s) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An ack in the timeout cycle still completes normally.
                if (mem_ack) begin
                    rdata_d = we_q ? {DATA_W{1'b0}} : rext_s;
                    state_d = ST_RESP;
                end else if (tmo_s) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign stall      = (idle_s & req_valid & legal_s) | access_s;
    assign misalign   = idle_s & req_valid & ~legal_s;
    assign mem_rd     = access_s & ~we_q;
    assign mem_wr     = access_s & we_q;
    assign mem_addr   = access_s ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : {ADDR_W{1'b0}};
    assign mem_wdata  = access_s ? wrep_s : {DATA_W{1'b0}};
    assign mem_be     = access_s ? be_s : {NB{1'b0}};
    assign resp_valid = resp_s;
    assign resp_rdata = resp_s ? rdata_q : {DATA_W{1'b0}};
    assign bus_err    = resp_s & err_q;

endmodule
